// File: rtl/bird_motion_ctrl.sv
// Flappy Bird physics sequencer: turns tick/flap edges into bird-row steps,
// runs the IDLE/RUN/DEAD game state machine and keeps a saturating score.
module bird_motion_ctrl #(
   parameter int ROWS      = 16,
   parameter int ROW_W     = 4,
   parameter int START_ROW = 7,
   parameter int FLAP_RISE = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             tick,
   input  logic             flap,
   input  logic             collide,
   input  logic             pass,
   output logic [ROW_W-1:0] row,
   output logic             alive,
   output logic             dead,
   output logic             step_out,
   output logic [7:0]       score
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DEAD = 2'd2;

   localparam logic [ROW_W-1:0] ROW_START  = ROW_W'(START_ROW);
   localparam logic [ROW_W-1:0] ROW_GROUND = ROW_W'(ROWS - 1);
   localparam logic [3:0]       RISE_INIT  = 4'(FLAP_RISE - 1);

   logic [1:0]       state_q, state_d;
   logic [ROW_W-1:0] row_q, row_d;
   logic [3:0]       rise_q, rise_d;
   logic             pend_q, pend_d;
   logic [7:0]       score_q, score_d;
   logic             step_out_q, step_out_d;
   logic             alive_q, dead_q;
   logic             tick_q, flap_q;

   logic step, fedge;
   logic [ROW_W-1:0] row_up;

   assign step   = tick & ~tick_q;
   assign fedge  = flap & ~flap_q;
   assign row_up = (row_q == '0) ? '0 : row_q - 1'b1;

   // NOTE: every variable gets a default before any branch, so no path leaves it unassigned (no latches).
   always_comb begin
      state_d    = state_q;
      row_d      = row_q;
      rise_d     = rise_q;
      pend_d     = pend_q;
      score_d    = score_q;
      step_out_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            row_d = ROW_START;
            if (fedge) begin
               state_d = ST_RUN;
               score_d = '0;
               rise_d  = '0;
               pend_d  = 1'b0;
            end
         end

         ST_RUN: begin
            if (fedge) pend_d = 1'b1;
            if (pass && score_q != 8'hFF) score_d = score_q + 8'd1;

            if (step) begin
               if (collide) begin
                  state_d = ST_DEAD;
                  pend_d  = 1'b0;
               end else if (pend_q || fedge) begin
                  rise_d     = RISE_INIT;
                  row_d      = row_up;
                  pend_d     = 1'b0;
                  step_out_d = 1'b1;
               end else if (rise_q != '0) begin
                  rise_d     = rise_q - 4'd1;
                  row_d      = row_up;
                  step_out_d = 1'b1;
               end else begin
                  step_out_d = 1'b1;
                  // Landing on the ground row ends the run on the same edge.
                  if (row_q >= ROW_GROUND - 1'b1) begin
                     row_d   = ROW_GROUND;
                     state_d = ST_DEAD;
                     pend_d  = 1'b0;
                  end else begin
                     row_d = row_q + 1'b1;
                  end
               end
            end
         end

         ST_DEAD: begin
            pend_d = 1'b0;
            if (fedge) begin
               state_d = ST_IDLE;
               row_d   = ROW_START;
            end
         end

         default: begin
            state_d = ST_IDLE;
            row_d   = ROW_START;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         row_q      <= ROW_START;
         rise_q     <= '0;
         pend_q     <= 1'b0;
         score_q    <= '0;
         step_out_q <= 1'b0;
         alive_q    <= 1'b0;
         dead_q     <= 1'b0;
         tick_q     <= 1'b0;
         flap_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         row_q      <= row_d;
         rise_q     <= rise_d;
         pend_q     <= pend_d;
         score_q    <= score_d;
         step_out_q <= step_out_d;
         alive_q    <= (state_d == ST_RUN);
         dead_q     <= (state_d == ST_DEAD);
         tick_q     <= tick;
         flap_q     <= flap;
      end
   end

   assign row      = row_q;
   assign alive    = alive_q;
   assign dead     = dead_q;
   assign step_out = step_out_q;
   assign score    = score_q;

endmodule

// File: tb/tb_bird_motion_ctrl.sv
// Directed self-checking bench for bird_motion_ctrl with hand-computed expectations.
module tb_bird_motion_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       tick, flap, collide, pass;
   logic [3:0] row;
   logic       alive, dead, step_out;
   logic [7:0] score;

   int passed = 0;
   int total  = 0;

   bird_motion_ctrl #(
      .ROWS(16), .ROW_W(4), .START_ROW(7), .FLAP_RISE(3)
   ) dut (
      .clk(clk), .reset(reset), .tick(tick), .flap(flap),
      .collide(collide), .pass(pass), .row(row), .alive(alive),
      .dead(dead), .step_out(step_out), .score(score)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   // One physics step: tick low for a cycle, then a rising edge with the given side inputs.
   // Returns just after the step edge so the caller can sample registered outputs.
   task automatic tick_step(input logic f, input logic c, input logic p);
      @(negedge clk); tick = 1'b0; flap = 1'b0; collide = 1'b0; pass = 1'b0;
      @(negedge clk); tick = 1'b1; flap = f; collide = c; pass = p;
      @(posedge clk); #1;
   endtask

   task automatic press_flap();
      @(negedge clk); tick = 1'b0; collide = 1'b0; pass = 1'b0; flap = 1'b1;
      @(negedge clk); flap = 1'b0;
   endtask

   task automatic pass_pulse();
      @(negedge clk); pass = 1'b1;
      @(negedge clk); pass = 1'b0;
   endtask

   initial begin
      reset = 1'b0; tick = 1'b0; flap = 1'b0; collide = 1'b0; pass = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_row", 16'(row), 16'd7);
      check("rst_alive", 16'(alive), 16'd0);
      check("rst_dead", 16'(dead), 16'd0);
      check("rst_score", 16'(score), 16'd0);
      @(negedge clk); reset = 1'b1;

      // Enter RUN; the starting press must not act as a flap.
      press_flap();
      check("run_alive", 16'(alive), 16'd1);
      check("run_row", 16'(row), 16'd7);

      // Climb to row 3 and score 5, then pull reset mid-cycle.
      press_flap();
      tick_step(0, 0, 0); check("climb_a", 16'(row), 16'd6);
      tick_step(0, 0, 0); check("climb_b", 16'(row), 16'd5);
      tick_step(0, 0, 0); check("climb_c", 16'(row), 16'd4);
      press_flap();
      tick_step(0, 0, 0); check("climb_d", 16'(row), 16'd3);
      for (int i = 0; i < 5; i++) pass_pulse();
      check("pre_rst_score", 16'(score), 16'd5);
      #2 reset = 1'b0;
      #1;
      check("async_row", 16'(row), 16'd7);
      check("async_alive", 16'(alive), 16'd0);
      check("async_dead", 16'(dead), 16'd0);
      check("async_score", 16'(score), 16'd0);
      @(negedge clk); reset = 1'b1;

      // IDLE ignores steps and pass pulses.
      for (int i = 0; i < 4; i++) begin
         tick_step(0, 0, 0);
         check("idle_row", 16'(row), 16'd7);
         check("idle_step", 16'(step_out), 16'd0);
      end
      pass_pulse();
      check("idle_pass", 16'(score), 16'd0);

      // Free fall to the ground: death lands on the 8th step with a step pulse.
      press_flap();
      for (int i = 0; i < 8; i++) begin
         tick_step(0, 0, 0);
         check("fall_row", 16'(row), 16'(8 + i));
         check("fall_step", 16'(step_out), 16'd1);
         check("fall_dead", 16'(dead), (i == 7) ? 16'd1 : 16'd0);
      end
      check("ground_alive", 16'(alive), 16'd0);
      @(posedge clk); #1;
      check("step_pulse_len", 16'(step_out), 16'd0);
      for (int i = 0; i < 2; i++) begin
         tick_step(0, 0, 0);
         check("dead_row", 16'(row), 16'd15);
         check("dead_step", 16'(step_out), 16'd0);
      end
      pass_pulse();
      check("dead_pass", 16'(score), 16'd0);

      // DEAD -> IDLE -> RUN.
      press_flap();
      check("restart_row", 16'(row), 16'd7);
      check("restart_dead", 16'(dead), 16'd0);
      press_flap();
      check("rerun_alive", 16'(alive), 16'd1);

      // Flap between ticks: rise of 3 then gravity.
      press_flap();
      tick_step(0, 0, 0); check("flap_r1", 16'(row), 16'd6);
      tick_step(0, 0, 0); check("flap_r2", 16'(row), 16'd5);
      tick_step(0, 0, 0); check("flap_r3", 16'(row), 16'd4);
      tick_step(0, 0, 0); check("flap_fall", 16'(row), 16'd5);
      tick_step(0, 0, 0); check("grav_6", 16'(row), 16'd6);
      tick_step(0, 0, 0); check("grav_7", 16'(row), 16'd7);

      // Flap coinciding with the tick, then several presses collapse into one restart.
      tick_step(1, 0, 0); check("coinc_row", 16'(row), 16'd6);
      press_flap(); press_flap(); press_flap();
      tick_step(0, 0, 0); check("restart_r1", 16'(row), 16'd5);
      tick_step(0, 0, 0); check("restart_r2", 16'(row), 16'd4);
      tick_step(0, 0, 0); check("restart_r3", 16'(row), 16'd3);
      tick_step(0, 0, 0); check("restart_fall", 16'(row), 16'd4);

      // Climb into the ceiling: row saturates at 0 without dying.
      press_flap();
      tick_step(0, 0, 0); tick_step(0, 0, 0); tick_step(0, 0, 0);
      check("near_top", 16'(row), 16'd1);
      press_flap();
      for (int i = 0; i < 3; i++) begin
         tick_step(0, 0, 0);
         check("ceil_row", 16'(row), 16'd0);
         check("ceil_alive", 16'(alive), 16'd1);
      end

      // A collide level with no tick edge is ignored; with a tick edge it kills.
      @(negedge clk); tick = 1'b1; collide = 1'b1;
      @(posedge clk); #1;
      check("collide_no_step", 16'(alive), 16'd1);
      tick_step(0, 1, 0);
      check("collide_dead", 16'(dead), 16'd1);
      check("collide_row", 16'(row), 16'd0);
      check("collide_step", 16'(step_out), 16'd0);

      // Score saturation and its hold across IDLE.
      press_flap(); press_flap();
      check("score_clear", 16'(score), 16'd0);
      for (int i = 0; i < 255; i++) pass_pulse();
      check("score_255", 16'(score), 16'd255);
      for (int i = 0; i < 45; i++) pass_pulse();
      check("score_sat", 16'(score), 16'd255);
      tick_step(0, 1, 0);
      check("sat_dead", 16'(dead), 16'd1);
      press_flap();
      check("idle_score_held", 16'(score), 16'd255);
      check("idle_row_back", 16'(row), 16'd7);
      press_flap();
      check("run_score_clear", 16'(score), 16'd0);

      // A pass on the death edge still counts.
      tick_step(0, 1, 1);
      check("death_pass_dead", 16'(dead), 16'd1);
      check("death_pass_score", 16'(score), 16'd1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
